// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory bus controller.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << lane;
            SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic sign_ext);
        logic [31:0] sh;
        logic [31:0] v;
        sh = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: v = {{24{sign_ext & sh[7]}}, sh[7:0]};
            SZ_HALF: v = {{16{sign_ext & sh[15]}}, sh[15:0]};
            default: v = word;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dmem_bus_ctrl_lane.sv
// Combinational byte-lane datapath: store merge into the old word and load extract/extend.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        sign_ext_i,
    output logic [31:0] new_word_o,
    output logic [31:0] load_val_o
);

    logic [3:0]  mask;
    logic [31:0] rep;

    assign mask = lane_mask(size_i, lane_i);

    // Replicate right-aligned store data onto every lane so the mask alone picks the target.
    always_comb begin
        rep = wdata_i;
        case (size_i)
            SZ_BYTE: rep = {4{wdata_i[7:0]}};
            SZ_HALF: rep = {2{wdata_i[15:0]}};
            default: rep = wdata_i;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign new_word_o[8*gi +: 8] = mask[gi] ? rep[8*gi +: 8] : old_word_i[8*gi +: 8];
        end
    endgenerate

    assign load_val_o = load_extend(old_word_i, size_i, lane_i, sign_ext_i);

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data memory with req/ready/ack handshake, wait states, sized loads/stores and fault reporting.
// The word is read at acceptance and committed one pass through WAIT later (WAIT_STATES+1 cycles).
module dmem_bus_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH          = 100,
    parameter int ADDR_W         = 32,
    parameter int WAIT_STATES    = 1,
    parameter int TEST_W         = 16,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              WE,
    input  logic [1:0]        SIZE,
    input  logic              SIGN_EXT,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       WDATA,
    output logic              READY,
    output logic              ACK,
    output logic [31:0]       RDATA,
    output logic              FAULT,
    output logic [TEST_W-1:0] TEST_RESULT
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] mem [DEPTH];

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [IDX_W-1:0]  clr_idx_q;
    logic [IDX_W-1:0]  idx_q;
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              sext_q;
    logic              pend_fault_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rd_word_q;
    logic              ready_q;
    logic              ack_q;
    logic              fault_q;
    logic [31:0]       rdata_q;
    logic [TEST_W-1:0] test_q;

    logic [ADDR_W-3:0] req_widx;
    logic              req_in_range;
    logic              req_fault;
    logic [IDX_W-1:0]  req_idx;
    logic              accept;
    logic              commit;
    logic              store_commit;
    logic [31:0]       new_word;
    logic [31:0]       load_val;
    logic              mem_we_d;
    logic [IDX_W-1:0]  mem_widx_d;
    logic [31:0]       mem_wdata_d;

    assign req_widx     = ADDR[ADDR_W-1:2];
    assign req_in_range = req_widx < (ADDR_W-2)'(DEPTH);
    assign req_fault    = (SIZE == 2'b11)
                        | ((SIZE == SZ_HALF) & ADDR[0])
                        | ((SIZE == SZ_WORD) & (ADDR[1:0] != 2'b00))
                        | !req_in_range;
    assign req_idx      = req_in_range ? ADDR[IDX_W+1:2] : '0;
    assign accept       = (state_q == IDLE) && ready_q && REQ;
    assign commit       = (state_q == WAIT) && (cnt_q == '0);
    assign store_commit = commit && we_q && !pend_fault_q;

    dmem_lane_unit u_lane (
        .old_word_i (rd_word_q),
        .wdata_i    (wdata_q),
        .size_i     (size_q),
        .lane_i     (lane_q),
        .sign_ext_i (sext_q),
        .new_word_o (new_word),
        .load_val_o (load_val)
    );

    always_comb begin
        mem_we_d    = 1'b0;
        mem_widx_d  = idx_q;
        mem_wdata_d = new_word;
        if (state_q == CLEAR) begin
            mem_we_d    = 1'b1;
            mem_widx_d  = clr_idx_q;
            mem_wdata_d = '0;
        end else if (store_commit) begin
            mem_we_d = 1'b1;
        end
    end

    // Array kept in plain clocked blocks so it maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (mem_we_d) mem[mem_widx_d] <= mem_wdata_d;
    end

    always_ff @(posedge CLK) begin
        if (accept) rd_word_q <= mem[req_idx];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            cnt_q        <= '0;
            clr_idx_q    <= '0;
            idx_q        <= '0;
            lane_q       <= '0;
            size_q       <= '0;
            we_q         <= 1'b0;
            sext_q       <= 1'b0;
            pend_fault_q <= 1'b0;
            wdata_q      <= '0;
            ready_q      <= 1'b0;
            ack_q        <= 1'b0;
            fault_q      <= 1'b0;
            rdata_q      <= '0;
            test_q       <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clr_idx_q == '0) test_q <= '0;
                    if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                        state_q   <= IDLE;
                        ready_q   <= 1'b1;
                        clr_idx_q <= '0;
                    end else begin
                        clr_idx_q <= clr_idx_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (REQ) begin
                        we_q         <= WE;
                        size_q       <= SIZE;
                        sext_q       <= SIGN_EXT;
                        lane_q       <= ADDR[1:0];
                        idx_q        <= req_idx;
                        wdata_q      <= WDATA;
                        pend_fault_q <= req_fault;
                        cnt_q        <= 4'(WAIT_STATES);
                        ready_q      <= 1'b0;
                        state_q      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        ack_q   <= 1'b1;
                        fault_q <= pend_fault_q;
                        rdata_q <= (pend_fault_q || we_q) ? 32'h0 : load_val;
                        if (store_commit && idx_q == '0) test_q <= new_word[TEST_W-1:0];
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    ack_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign READY       = ready_q;
    assign ACK         = ack_q;
    assign RDATA       = rdata_q;
    assign FAULT       = fault_q;
    assign TEST_RESULT = test_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed plus random load/store sequence checked against a byte-addressed memory model.
module tb_dmem_bus_ctrl;

    localparam int DEPTH  = 100;
    localparam int WS     = 1;
    localparam int TEST_W = 16;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              REQ = 1'b0;
    logic              WE = 1'b0;
    logic [1:0]        SIZE = 2'b00;
    logic              SIGN_EXT = 1'b0;
    logic [31:0]       ADDR = 32'h0;
    logic [31:0]       WDATA = 32'h0;
    logic              READY;
    logic              ACK;
    logic [31:0]       RDATA;
    logic              FAULT;
    logic [TEST_W-1:0] TEST_RESULT;

    int errors = 0;
    int checks = 0;
    logic [7:0] ref_mem [DEPTH*4];

    dmem_bus_ctrl #(
        .DEPTH(DEPTH), .ADDR_W(32), .WAIT_STATES(WS), .TEST_W(TEST_W), .CLEAR_ON_RESET(1)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .SIZE(SIZE), .SIGN_EXT(SIGN_EXT),
        .ADDR(ADDR), .WDATA(WDATA), .READY(READY), .ACK(ACK), .RDATA(RDATA),
        .FAULT(FAULT), .TEST_RESULT(TEST_RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_fault(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
               || ((a >> 2) >= DEPTH);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
        logic [31:0] v;
        int n;
        n = nbytes(sz);
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
        if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [15:0] ref_test();
        return {ref_mem[1], ref_mem[0]};
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < DEPTH * 4; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic wait_accept(output logic ok);
        logic rb;
        int guard;
        ok = 1'b0;
        guard = 0;
        while (!ok && guard < 300) begin
            rb = READY;
            @(posedge CLK);
            guard++;
            if (rb) ok = 1'b1;
            else @(negedge CLK);
        end
    endtask

    task automatic access(input string tag, input logic we, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd);
        logic        exp_fault;
        logic [31:0] exp_rdata;
        logic        ok;
        logic        got;
        int          lat;
        exp_fault = ref_fault(a, sz);
        exp_rdata = 32'h0;
        if (!exp_fault) begin
            if (we) begin
                for (int i = 0; i < nbytes(sz); i++) ref_mem[a + i] = wd[8*i +: 8];
            end else begin
                exp_rdata = ref_load(a, sz, sx);
            end
        end
        @(negedge CLK);
        REQ = 1'b1; WE = we; SIZE = sz; SIGN_EXT = sx; ADDR = a; WDATA = wd;
        wait_accept(ok);
        check({tag, "/accept"}, 32'(ok), 32'd1);
        #1 REQ = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 50) begin
            @(posedge CLK); #1;
            lat++;
            if (ACK) got = 1'b1;
        end
        check({tag, "/latency"}, 32'(lat), 32'(WS + 1));
        check({tag, "/fault"}, 32'(FAULT), 32'(exp_fault));
        if (!we || exp_fault) check({tag, "/rdata"}, RDATA, exp_rdata);
        check({tag, "/test_result"}, 32'(TEST_RESULT), 32'(ref_test()));
        $display("txn %s we=%0d size=%0d sext=%0d addr=%h wdata=%h rdata=%h fault=%0d lat=%0d",
                 tag, we, sz, sx, a, wd, RDATA, FAULT, lat);
        @(posedge CLK); #1;
        check({tag, "/ack_pulse"}, 32'(ACK), 32'd0);
    endtask

    task automatic release_and_sweep(input string tag);
        int  n;
        logic ack_seen;
        @(negedge CLK);
        RST = 1'b1;
        n = 0;
        ack_seen = 1'b0;
        while (n < 1000) begin
            @(posedge CLK); #1;
            n++;
            if (ACK) ack_seen = 1'b1;
            if (READY) break;
        end
        check({tag, "/ready_cycles"}, 32'(n), 32'(DEPTH));
        check({tag, "/no_ack_in_sweep"}, 32'(ack_seen), 32'd0);
        check({tag, "/test_result"}, 32'(TEST_RESULT), 32'h0);
        $display("txn %s sweep cycles=%0d", tag, n);
    endtask

    initial begin
        logic        ok;
        logic        we;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] a;

        ref_clear();
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset/ready", 32'(READY), 32'd0);
        check("reset/ack", 32'(ACK), 32'd0);
        check("reset/fault", 32'(FAULT), 32'd0);
        check("reset/rdata", RDATA, 32'h0);
        check("reset/test_result", 32'(TEST_RESULT), 32'h0);
        release_and_sweep("sweep0");

        access("lw0_init", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        access("sw0",      1'b1, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF);
        access("lw0_a",    1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        access("lw0_b",    1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        access("sw4",      1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344);
        access("sb5",      1'b1, 2'b00, 1'b0, 32'h5, 32'h00000080);
        access("lw4",      1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        access("lb5",      1'b0, 2'b00, 1'b1, 32'h5, 32'h0);
        access("lbu5",     1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
        access("lh6",      1'b0, 2'b01, 1'b1, 32'h6, 32'h0);
        access("lh3_mis",  1'b0, 2'b01, 1'b1, 32'h3, 32'h0);
        access("sw2_mis",  1'b1, 2'b10, 1'b0, 32'h2, 32'hFFFFFFFF);
        access("lw0_keep", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        access("lw400",    1'b0, 2'b10, 1'b0, 32'd400, 32'h0);
        access("lw4_ok",   1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        access("sz11",     1'b1, 2'b11, 1'b0, 32'h8, 32'h12345678);
        access("sh_hi",    1'b1, 2'b01, 1'b0, 32'h2, 32'h0000A5F0);
        access("lh_hi",    1'b0, 2'b01, 1'b1, 32'h2, 32'h0);

        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sx = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(392, 420))
                                             : 32'($urandom_range(0, 47));
            access($sformatf("rnd%0d", i), we, sz, sx, a, $urandom);
        end

        // Reset while a store waits: the store must vanish and the sweep restart.
        @(negedge CLK);
        REQ = 1'b1; WE = 1'b1; SIZE = 2'b10; SIGN_EXT = 1'b0; ADDR = 32'h8; WDATA = 32'h55;
        wait_accept(ok);
        check("rst_mid/accept", 32'(ok), 32'd1);
        #1 REQ = 1'b0;
        @(negedge CLK);
        check("rst_mid/ready_in_wait", 32'(READY), 32'd0);
        RST = 1'b0;
        ref_clear();
        #1;
        check("rst_mid/ack", 32'(ACK), 32'd0);
        check("rst_mid/ready", 32'(READY), 32'd0);
        repeat (2) @(negedge CLK);
        check("rst_mid/ack_held", 32'(ACK), 32'd0);
        release_and_sweep("sweep1");
        access("lw8_after", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        access("lw0_after", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
